// File: rtl/game_session_ctrl.sv
// -----------------------------------------------------------------------------
// game_session_ctrl
//
// Session-level game controller. Sequences a game through
// IDLE -> GENERATING -> RUNNING <-> PAUSED -> GAME_OVER. It also tracks the
// score (rounds won), the 0-based level number and the remaining lives, and
// can optionally track the best score.
//
// Optional feature macro: GAME_SESSION_BEST_SCORE_EN
//   defined     : keeps a best-score register that survives restarts and is
//                 cleared only by rst_n. o_new_best pulses on each update.
//   not defined : o_best_score and o_new_best are tied to zero.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_start          pulse: start/restart (honoured in IDLE and GAME_OVER)
//   i_level_ready    level generator done (honoured in GENERATING)
//   i_round_ended    pulse: round finished (honoured in RUNNING)
//   i_is_win         round result, qualified by i_round_ended
//   i_pause_toggle   pulse: pause/resume
//   o_state          state code: 0 IDLE, 1 GENERATING, 2 RUNNING, 3 PAUSED,
//                    4 GAME_OVER
//   o_is_paused      high while PAUSED
//   o_score          rounds won, saturating
//   o_level          current level, saturating
//   o_lives          remaining lives
//   o_best_score     best score since reset
//   o_new_best       one-cycle pulse when o_best_score updates
// -----------------------------------------------------------------------------
module game_session_ctrl #(
    parameter int SCORE_WIDTH = 8,
    parameter int LEVEL_WIDTH = 6,
    parameter int LIVES       = 3,
    localparam int LIVES_WIDTH = $clog2(LIVES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic                   i_level_ready,
    input  logic                   i_round_ended,
    input  logic                   i_is_win,
    input  logic                   i_pause_toggle,
    output logic [2:0]             o_state,
    output logic                   o_is_paused,
    output logic [SCORE_WIDTH-1:0] o_score,
    output logic [LEVEL_WIDTH-1:0] o_level,
    output logic [LIVES_WIDTH-1:0] o_lives,
    output logic [SCORE_WIDTH-1:0] o_best_score,
    output logic                   o_new_best
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GENERATING = 3'd1,
        ST_RUNNING    = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};
    localparam logic [SCORE_WIDTH-1:0] SCORE_ZERO = {SCORE_WIDTH{1'b0}};
    localparam logic [SCORE_WIDTH-1:0] SCORE_ONE  = SCORE_WIDTH'(1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = {LEVEL_WIDTH{1'b1}};
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_ZERO = {LEVEL_WIDTH{1'b0}};
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_ONE  = LEVEL_WIDTH'(1);
    localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);
    localparam logic [LIVES_WIDTH-1:0] LIVES_ZERO = {LIVES_WIDTH{1'b0}};
    localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic [LIVES_WIDTH-1:0] lives_q, lives_d;
    logic                   paused_q;

    // Next-state and counter update for the session FSM.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        level_d = level_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (i_start) begin
                    state_d = ST_GENERATING;
                    score_d = SCORE_ZERO;
                    level_d = LEVEL_ZERO;
                    lives_d = LIVES_INIT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GENERATING: begin
                if (i_level_ready) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_GENERATING;
                end
            end
            ST_RUNNING: begin
                // A round end takes priority over a pause toggle in the same cycle.
                if (i_round_ended) begin
                    if (i_is_win) begin
                        state_d = ST_GENERATING;
                        score_d = (score_q == SCORE_MAX) ? SCORE_MAX : score_q + SCORE_ONE;
                        level_d = (level_q == LEVEL_MAX) ? LEVEL_MAX : level_q + LEVEL_ONE;
                    end else if (lives_q <= LIVES_ONE) begin
                        state_d = ST_GAME_OVER;
                        lives_d = LIVES_ZERO;
                    end else begin
                        // Lost a life: replay the same level.
                        state_d = ST_GENERATING;
                        lives_d = lives_q - LIVES_ONE;
                    end
                end else if (i_pause_toggle) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                if (i_pause_toggle) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                // Unused encodings fall back to IDLE.
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            score_q  <= SCORE_ZERO;
            level_q  <= LEVEL_ZERO;
            lives_q  <= LIVES_INIT;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
            paused_q <= (state_d == ST_PAUSED);
        end
    end

`ifdef GAME_SESSION_BEST_SCORE_EN
    logic [SCORE_WIDTH-1:0] best_q, best_d;
    logic                   new_best_q, new_best_d;

    // Best score follows the registered score one cycle later.
    always_comb begin
        best_d     = best_q;
        new_best_d = 1'b0;
        if (score_q > best_q) begin
            best_d     = score_q;
            new_best_d = 1'b1;
        end else begin
            best_d     = best_q;
            new_best_d = 1'b0;
        end
    end

    // Best-score registers; only rst_n clears them, restarts do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= SCORE_ZERO;
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign o_best_score = best_q;
    assign o_new_best   = new_best_q;
`else
    assign o_best_score = SCORE_ZERO;
    assign o_new_best   = 1'b0;
`endif

    assign o_state     = state_q;
    assign o_is_paused = paused_q;
    assign o_score     = score_q;
    assign o_level     = level_q;
    assign o_lives     = lives_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
module tb_game_session_ctrl;

`ifdef GAME_SESSION_BEST_SCORE_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_start = 1'b0, i_level_ready = 1'b0, i_round_ended = 1'b0;
    logic i_is_win = 1'b0, i_pause_toggle = 1'b0;

    // Default-width instance
    logic [2:0] a_state; logic a_paused; logic [7:0] a_score; logic [5:0] a_level;
    logic [1:0] a_lives; logic [7:0] a_best; logic a_nb;
    // Narrow instance (2-bit score and level) for saturation
    logic [2:0] b_state; logic b_paused; logic [1:0] b_score; logic [1:0] b_level;
    logic [1:0] b_lives; logic [1:0] b_best; logic b_nb;

    game_session_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_level_ready(i_level_ready),
        .i_round_ended(i_round_ended), .i_is_win(i_is_win), .i_pause_toggle(i_pause_toggle),
        .o_state(a_state), .o_is_paused(a_paused), .o_score(a_score), .o_level(a_level),
        .o_lives(a_lives), .o_best_score(a_best), .o_new_best(a_nb)
    );

    game_session_ctrl #(.SCORE_WIDTH(2), .LEVEL_WIDTH(2), .LIVES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_level_ready(i_level_ready),
        .i_round_ended(i_round_ended), .i_is_win(i_is_win), .i_pause_toggle(i_pause_toggle),
        .o_state(b_state), .o_is_paused(b_paused), .o_score(b_score), .o_level(b_level),
        .o_lives(b_lives), .o_best_score(b_best), .o_new_best(b_nb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int state; int score; int level; int lives; int best; int nb; int paused;
    } mstate_t;

    typedef struct { mstate_t a; mstate_t b; } exp_t;

    mstate_t model_a, model_b;
    exp_t    sb_q[$];
    int      vectors_applied = 0;
    int      miscompares = 0;
    int      b_nb_count = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic mstate_t model_reset();
        mstate_t m;
        m.state = 0; m.score = 0; m.level = 0; m.lives = 3;
        m.best = 0; m.nb = 0; m.paused = 0;
        return m;
    endfunction

    // Reference behaviour of one session controller for one clock edge.
    function automatic mstate_t model_step(input mstate_t m, input bit st, input bit rdy,
                                           input bit re, input bit win, input bit tog,
                                           input int smax, input int lmax);
        mstate_t n = m;
        if (BEST_EN && m.score > m.best) begin
            n.best = m.score; n.nb = 1;
        end else begin
            n.nb = 0;
        end
        case (m.state)
            0, 4: if (st) begin n.state = 1; n.score = 0; n.level = 0; n.lives = 3; end
            1: if (rdy) n.state = 2;
            2: begin
                if (re && win) begin
                    n.state = 1;
                    if (m.score < smax) n.score = m.score + 1;
                    if (m.level < lmax) n.level = m.level + 1;
                end else if (re) begin
                    if (m.lives == 1) begin n.state = 4; n.lives = 0; end
                    else begin n.state = 1; n.lives = m.lives - 1; end
                end else if (tog) n.state = 3;
            end
            3: if (tog) n.state = 2;
            default: n.state = 0;
        endcase
        n.paused = (n.state == 3) ? 1 : 0;
        return n;
    endfunction

    task automatic compare_all(input mstate_t ea, input mstate_t eb);
        check_eq("a_state", int'(a_state), ea.state);
        check_eq("a_score", int'(a_score), ea.score);
        check_eq("a_level", int'(a_level), ea.level);
        check_eq("a_lives", int'(a_lives), ea.lives);
        check_eq("a_best", int'(a_best), ea.best);
        check_eq("a_new_best", int'(a_nb), ea.nb);
        check_eq("a_paused", int'(a_paused), ea.paused);
        check_eq("b_state", int'(b_state), eb.state);
        check_eq("b_score", int'(b_score), eb.score);
        check_eq("b_level", int'(b_level), eb.level);
        check_eq("b_lives", int'(b_lives), eb.lives);
        check_eq("b_best", int'(b_best), eb.best);
        check_eq("b_new_best", int'(b_nb), eb.nb);
        check_eq("b_paused", int'(b_paused), eb.paused);
    endtask

    // Drive one cycle of stimulus, push the prediction, then pop and compare.
    task automatic drive(input bit st, input bit rdy, input bit re, input bit win, input bit tog);
        exp_t e;
        i_start = st; i_level_ready = rdy; i_round_ended = re; i_is_win = win; i_pause_toggle = tog;
        e.a = model_step(model_a, st, rdy, re, win, tog, 255, 63);
        e.b = model_step(model_b, st, rdy, re, win, tog, 3, 3);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        i_start = 1'b0; i_level_ready = 1'b0; i_round_ended = 1'b0;
        i_is_win = 1'b0; i_pause_toggle = 1'b0;
        e = sb_q.pop_front();
        model_a = e.a; model_b = e.b;
        if (b_nb) b_nb_count++;
        compare_all(e.a, e.b);
    endtask

    task automatic win_round();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_a = model_reset(); model_b = model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all(model_a, model_b);
        rst_n = 1'b1;

        // Idle with no start stays idle; round/ready ignored
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        // T2: start, ready, three wins each followed by ready
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t2_gen_after_start", int'(a_state), 1);
        // GENERATING ignores everything but ready
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        win_round(); win_round();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t2_score", int'(a_score), 3);
        check_eq("t2_level", int'(a_level), 3);
        check_eq("t2_state", int'(a_state), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // T6: two more wins -> narrow instance saturates at 3
        win_round(); win_round();
        check_eq("t6_b_score_sat", int'(b_score), 3);
        check_eq("t6_b_level_sat", int'(b_level), 3);
        check_eq("t6_a_score", int'(a_score), 5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_b_best", int'(b_best), BEST_EN ? 3 : 0);
        check_eq("t6_b_new_best_pulses", b_nb_count, BEST_EN ? 3 : 0);

        // T4: pause, win ignored while paused, start ignored, resume
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_paused_state", int'(a_state), 3);
        check_eq("t4_is_paused", int'(a_paused), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t4_score_frozen", int'(a_score), 5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t4_resumed", int'(a_state), 2);
        // Start ignored while running
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // T5: round end wins over pause toggle
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("t5_state", int'(a_state), 1);
        check_eq("t5_score", int'(a_score), 6);
        check_eq("t5_not_paused", int'(a_paused), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // T3: three losses -> game over
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_lives2", int'(a_lives), 2);
        check_eq("t3_level_kept", int'(a_level), 6);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_lives1", int'(a_lives), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("t3_game_over", int'(a_state), 4);
        check_eq("t3_lives0", int'(a_lives), 0);
        // Round end ignored in GAME_OVER, lives do not underflow
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t3_restart_lives", int'(a_lives), 3);
        check_eq("t3_restart_score", int'(a_score), 0);
        check_eq("t6_best_survives", int'(b_best), BEST_EN ? 3 : 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // T1: build score to 5, then reset mid-RUNNING
        for (int i = 0; i < 5; i++) win_round();
        check_eq("t1_pre_score", int'(a_score), 5);
        check_eq("t1_pre_state", int'(a_state), 2);
        rst_n = 1'b0;
        #1;
        model_a = model_reset(); model_b = model_reset();
        check_eq("t1_async_state", int'(a_state), 0);
        @(posedge clk);
        #1;
        check_eq("t1_state", int'(a_state), 0);
        check_eq("t1_score", int'(a_score), 0);
        check_eq("t1_level", int'(a_level), 0);
        check_eq("t1_lives", int'(a_lives), 3);
        compare_all(model_a, model_b);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
